// File: rtl/mano_mem_seq.sv
// mano_mem_seq: multi-cycle memory access sequencer for the Mano basic computer
module mano_mem_seq #(
  parameter int NT          = 8,
  parameter int WAIT_STATES = 1,
  parameter int USE_READY   = 1,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NT-1:0]    T,
  input  logic [7:0]       D,
  input  logic             J,
  input  logic             mem_ready,
  output logic             READ,
  output logic             WRITE,
  output logic             stall,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT_RDY, DONE} state_t;
  state_t state_q, state_d;
  logic dir_q, dir_d, armed_q, armed_d, err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic [NT-1:0] t_lat_q, t_lat_d;
  logic [CNT_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic rd_req, wr_req, start, busy, unused_ok;
  assign rd_req = T[1] | (~D[7] & J & T[3]) | ((D[0] | D[1] | D[2] | D[6]) & T[4]);
  assign wr_req = ((D[3] | D[5]) & T[4]) | (D[6] & T[6]);
  assign start = (state_q == IDLE) & (rd_req | wr_req) & armed_q;
  assign busy = (state_q == ACCESS) | (state_q == WAIT_RDY);
  // stall is gated by rst so an async reset drops it even while a request is pending
  assign stall = ~rst & (start | busy);
  assign READ = busy & ~dir_q;
  assign WRITE = busy & dir_q;
  assign done = state_q == DONE;
  assign err = err_q;
  assign rd_count = rd_q;
  assign wr_count = wr_q;
  assign unused_ok = ^{D[4], T};
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    t_lat_d = t_lat_q;
    err_d = err_q;
    rd_d = rd_q;
    wr_d = wr_q;
    armed_d = armed_q | (((state_q == IDLE) | (state_q == DONE)) & (T != t_lat_q));
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ACCESS;
        t_lat_d = T;
        dir_d = wr_req;
        cnt_d = 8'd0;
        armed_d = 1'b0;
        err_d = err_q | (rd_req & wr_req);
      end
      ACCESS: if (cnt_q == 8'(WAIT_STATES)) begin
        state_d = (USE_READY != 0) ? WAIT_RDY : DONE;
        cnt_d = 8'd0;
      end else cnt_d = cnt_q + 8'd1;
      WAIT_RDY: if (mem_ready) state_d = DONE;
      else if (TIMEOUT != 0 && cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = DONE;
        err_d = 1'b1;
      end else cnt_d = cnt_q + 8'd1;
      DONE: begin
        state_d = IDLE;
        rd_d = (~dir_q & ~&rd_q) ? rd_q + 1'b1 : rd_q;
        wr_d = (dir_q & ~&wr_q) ? wr_q + 1'b1 : wr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      armed_q <= 1'b1;
      err_q <= 1'b0;
      cnt_q <= '0;
      t_lat_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      armed_q <= armed_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
      t_lat_q <= t_lat_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end
endmodule

// File: tb/tb_mano_mem_seq.sv
// tb_mano_mem_seq: directed vectors over four parameter sets sharing one input bus
module tb_mano_mem_seq;
  logic clk, rst, J, mem_ready;
  logic [7:0] T, D;
  logic [3:0] stall_v, rd_v, wr_v, done_v, err_v;
  logic [15:0] rc_a, wc_a, rc_b, wc_b, rc_c, wc_c;
  logic [1:0] rc_d, wc_d;
  int n_vec, n_bad, ns, nr, nw, nd, fd, sc, tot;
  mano_mem_seq #(.WAIT_STATES(1), .USE_READY(0)) u_a (.clk(clk), .rst(rst), .T(T), .D(D), .J(J),
    .mem_ready(mem_ready), .READ(rd_v[0]), .WRITE(wr_v[0]), .stall(stall_v[0]), .done(done_v[0]),
    .err(err_v[0]), .rd_count(rc_a), .wr_count(wc_a));
  mano_mem_seq #(.WAIT_STATES(1), .USE_READY(1), .TIMEOUT(16)) u_b (.clk(clk), .rst(rst), .T(T), .D(D),
    .J(J), .mem_ready(mem_ready), .READ(rd_v[1]), .WRITE(wr_v[1]), .stall(stall_v[1]), .done(done_v[1]),
    .err(err_v[1]), .rd_count(rc_b), .wr_count(wc_b));
  mano_mem_seq #(.WAIT_STATES(1), .USE_READY(1), .TIMEOUT(3)) u_c (.clk(clk), .rst(rst), .T(T), .D(D),
    .J(J), .mem_ready(mem_ready), .READ(rd_v[2]), .WRITE(wr_v[2]), .stall(stall_v[2]), .done(done_v[2]),
    .err(err_v[2]), .rd_count(rc_c), .wr_count(wc_c));
  mano_mem_seq #(.WAIT_STATES(0), .USE_READY(0), .CNT_W(2)) u_d (.clk(clk), .rst(rst), .T(T), .D(D),
    .J(J), .mem_ready(mem_ready), .READ(rd_v[3]), .WRITE(wr_v[3]), .stall(stall_v[3]), .done(done_v[3]),
    .err(err_v[3]), .rd_count(rc_d), .wr_count(wc_d));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic reset_all();
    tick();
    rst = 1'b1;
    T = '0;
    D = '0;
    J = 1'b0;
    mem_ready = 1'b0;
    sc = 1;
    #1;
    rst = 1'b0;
    tick();
  endtask
  // n cycles on instance idx; cycle 0 is the request cycle; adv emulates the sequence counter
  task automatic win(input int n, input int idx, input int rdy_at, input bit adv);
    logic s;
    ns = 0; nr = 0; nw = 0; nd = 0; fd = -1;
    for (int i = 0; i < n; i++) begin
      if (adv) T = 8'(1 << sc);
      if (i == rdy_at) mem_ready = 1'b1;
      #1;
      s = stall_v[idx];
      ns += int'(s);
      nr += int'(rd_v[idx]);
      nw += int'(wr_v[idx]);
      nd += int'(done_v[idx]);
      if (done_v[idx] && fd < 0) fd = i;
      tick();
      if (adv && !s) sc++;
    end
    mem_ready = 1'b0;
  endtask
  initial begin
    n_vec = 0; n_bad = 0; sc = 1;
    rst = 1'b1; T = '0; D = '0; J = 1'b0; mem_ready = 1'b0;
    reset_all();
    chk("rst_stall", stall_v, 0);
    chk("rst_strobe", {rd_v, wr_v}, 0);
    chk("rst_done_err", {done_v, err_v}, 0);
    chk("rst_counts", {rc_a, wc_b, rc_c, 2'b00, rc_d}, 0);
    T = 8'h02;
    win(8, 0, -1, 0);
    chk("fetch_stall", ns, 3);
    chk("fetch_read", nr, 2);
    chk("fetch_write", nw, 0);
    chk("fetch_done_once", nd, 1);
    chk("fetch_done_at", fd, 3);
    chk("fetch_rd_count", rc_a, 1);
    T = 8'h00;
    tick();
    T = 8'h02;
    tick();
    chk("mid_read", rd_v[0], 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_read", rd_v[0], 0);
    chk("mid_rst_stall", stall_v[0], 0);
    chk("mid_rst_done", done_v[0], 0);
    chk("mid_rst_count", rc_a, 0);
    rst = 1'b0;
    win(6, 0, -1, 0);
    chk("post_rst_stall", ns, 3);
    chk("post_rst_read", nr, 2);
    chk("post_rst_count", rc_a, 1);
    reset_all();
    D = 8'h08; T = 8'h10;
    win(12, 1, 7, 0);
    chk("sta_stall", ns, 8);
    chk("sta_write", nw, 7);
    chk("sta_read", nr, 0);
    chk("sta_done_at", fd, 8);
    chk("sta_wr_count", wc_b, 1);
    chk("sta_err", err_v[1], 0);
    reset_all();
    T = 8'h02;
    win(6, 1, 0, 0);
    chk("rdy_held_stall", ns, 4);
    chk("rdy_held_read", nr, 3);
    chk("rdy_held_done_at", fd, 4);
    reset_all();
    J = 1'b1; T = 8'h08;
    win(6, 0, -1, 0);
    chk("ind_read", nr, 2);
    chk("ind_stall", ns, 3);
    reset_all();
    J = 1'b1; D = 8'h80; T = 8'h08;
    #1;
    chk("ind_d7_stall_now", stall_v[0], 0);
    win(6, 0, -1, 0);
    chk("ind_d7_stall", ns, 0);
    reset_all();
    J = 1'b1; D = 8'hff; T = 8'h80;
    win(4, 0, -1, 0);
    chk("t7_no_req", ns, 0);
    reset_all();
    T = 8'h02;
    win(8, 2, -1, 0);
    chk("tmo_stall", ns, 6);
    chk("tmo_read", nr, 5);
    chk("tmo_done_at", fd, 6);
    chk("tmo_err", err_v[2], 1);
    chk("tmo_rd_count", rc_c, 1);
    chk("no_tmo_err_a", err_v[0], 0);
    T = 8'h00;
    repeat (10) tick();
    chk("tmo_err_sticky", err_v[2], 1);
    reset_all();
    D = 8'h09; T = 8'h10;
    win(6, 0, -1, 0);
    chk("cfl_write", nw, 2);
    chk("cfl_read", nr, 0);
    chk("cfl_err", err_v[0], 1);
    chk("cfl_counts", {wc_a, rc_a}, {16'd1, 16'd0});
    reset_all();
    J = 1'b1; sc = 1;
    win(12, 0, -1, 1);
    chk("b2b_done", nd, 2);
    chk("b2b_read", nr, 4);
    chk("b2b_rd_count", rc_a, 2);
    reset_all();
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      T = 8'h00;
      tick();
      T = 8'h02;
      win(3, 3, -1, 0);
      tot += ns;
    end
    chk("sat_stall_total", tot, 10);
    chk("sat_rd_count", rc_d, 3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mano_mem_seq.md
Name: mano_mem_seq

Overview:
- Parametrised memory-cycle sequencer for the Mano basic computer; successor to the purely combinational memory read/write decode.
- Decodes read and write requests from the decoded opcode D, the indirect bit J and the timing signals T.
- Runs each access as a multi-cycle bus cycle with programmable wait states, an optional memory-ready handshake and a timeout.
- Asserts stall to freeze the sequence counter until the access completes. Sits between the control unit and memory.

Parameters:
- NT, 8: width of one-hot timing bus T; must be at least 7.
- WAIT_STATES, 1: extra strobe cycles per access; range 0..15.
- USE_READY, 1: 1 means wait for mem_ready after the wait states; 0 means ignore mem_ready.
- TIMEOUT, 16: maximum WAIT_RDY cycles before forced completion; 0 disables the timeout; range 0..255.
- CNT_W, 16: width of the saturating access counters.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- T, input, NT: one-hot timing signals from the sequence counter decoder.
- D, input, 8: decoded opcode D0..D7.
- J, input, 1: indirect-address bit.
- mem_ready, input, 1: memory completion, sampled in WAIT_RDY.
- READ, output, 1: memory read strobe.
- WRITE, output, 1: memory write strobe.
- stall, output, 1: holds the sequence counter while high.
- done, output, 1: one-cycle pulse at access completion.
- err, output, 1: sticky; set on timeout or on a read/write conflict.
- rd_count, output, CNT_W: completed reads, saturating.
- wr_count, output, CNT_W: completed writes, saturating.

Behaviour:
- Reset: all of the following take effect immediately, mid-access included. State goes to IDLE. READ, WRITE, stall, done and err go to 0. Both counters go to 0. armed goes to 1. t_lat goes to 0.
- Request decode (combinational):
  - rd_req = T1 | (~D7 & J & T3) | ((D0|D1|D2|D6) & T4).
  - wr_req = (D3 & T4) | (D5 & T4) | (D6 & T6).
  - req = rd_req | wr_req.
- Conflict: if rd_req and wr_req are both high when an access starts, the write wins and err is set.
- Arming:
  - armed clears on entry to ACCESS.
  - armed re-sets on any cycle in IDLE or DONE where T differs from t_lat.
  - This stops re-triggering while T is held at the same value.
- IDLE:
  - If req & armed: stall=1 combinationally in that same cycle. t_lat<=T, dir<=wr_req, cnt<=0, and next state is ACCESS.
  - Otherwise stall=0.
- ACCESS:
  - READ=~dir, WRITE=dir, stall=1.
  - Lasts exactly WAIT_STATES+1 cycles, counted by cnt.
  - Then goes to WAIT_RDY if USE_READY=1, else to DONE.
- WAIT_RDY:
  - Strobe held, stall=1.
  - Exits to DONE on the first cycle mem_ready=1 is sampled.
  - With TIMEOUT>0, a cycle counter runs. If TIMEOUT cycles pass without mem_ready, err<=1 and the state goes to DONE.
- DONE: exactly one cycle.
  - READ=WRITE=0, stall=0, done=1.
  - rd_count or wr_count increments by 1, saturating at all-ones.
  - The increment also applies on a timeout completion.
  - Next state is IDLE.
- Latency with USE_READY=0: the request cycle plus WAIT_STATES+1 strobe cycles plus 1 DONE cycle, so stall is high for WAIT_STATES+2 cycles. With WAIT_STATES=0 the strobe is 1 cycle.
- mem_ready high before WAIT_RDY is ignored. mem_ready held high means WAIT_RDY lasts exactly 1 cycle.
- err clears only on rst.
- Strobes are registered state decodes; stall in IDLE is the only combinational path from an input to an output.
- An unused T index beyond NT-1 never produces a request.

Test Plan:
- Fetch read, WAIT_STATES=1, USE_READY=0. Pulse T1 with SC held by stall. Expect stall high 3 cycles, READ high 2 cycles, done at cycle 3, rd_count=1, then no retrigger while T1 stays high.
- STA write, D3=1, T4, USE_READY=1, mem_ready raised 4 cycles into WAIT_RDY. Expect WRITE high 2+5 cycles, done 1 cycle later, wr_count=1, READ never high.
- Indirect read, D7=0, J=1, T3. Expect a read. Same with D7=1: expect no request, stall=0.
- Timeout, TIMEOUT=3, mem_ready=0. Expect 3 WAIT_RDY cycles, then err=1, done=1, rd_count=1, and err still 1 after 10 idle cycles.
- Conflict: force D0=1 and D3=1 at T4. Expect WRITE, not READ, and err=1. Back-to-back T1 then T2 then T3 indirect: exactly 2 accesses.
- Reset mid-ACCESS: assert rst while READ=1. Expect READ, stall and done at 0 immediately, counters 0, and a fresh access on the next req after release. Saturation check: CNT_W=2, 5 reads gives rd_count=3.
